// File: rtl/execute_cycle_pkg.sv
// execute_cycle_pkg
//   Shared definitions for the execute stage: datapath widths, ALU operation
//   codes and forwarding-select codes. Imported by execute_cycle and ex_alu.
package execute_cycle_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/execute_cycle_alu.sv
// ex_alu
//   Combinational 32-bit ALU for the execute stage.
//   Ports:
//     A, B        in  32  operands
//     ALUControl  in  3   operation (add, sub, and, or, signed slt; others -> 0)
//     Result      out 32  result modulo 2^32
//     Zero        out 1   Result == 0
module ex_alu
    import execute_cycle_pkg::*;
(
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = A + B;
            ALU_SUB: Result = A - B;
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// execute_cycle
//   Execute stage of a 5-stage pipeline: operand forwarding muxes, ALU,
//   branch resolution and the EX/MEM pipeline register.
//   Build option: define EXECUTE_FWD_EN to enable the forwarding muxes;
//   without it ForwardAE/ForwardBE/ResultW are ignored and the register
//   file operands are used directly (ports stay present).
//   Ports:
//     clk, rst                 clock, async active-low reset
//     RegWriteE..ALUSrcE       ID/EX control bits
//     ALUControlE              ALU operation
//     RD1_E, RD2_E, Imm_Ext_E  operands and immediate
//     PCE, PCPlus4E            PC and PC+4 of the instruction in execute
//     RS1_E, RS2_E, RD_E       register indices
//     ResultW                  writeback result for forwarding
//     ForwardAE, ForwardBE     operand selects (00 reg, 01 WB, 10 MEM)
//     FlushE                   kill the instruction in execute
//     PCSrcE, PCTargetE        branch taken / target (combinational)
//     RegWriteM..PCPlus4M      EX/MEM register outputs
module execute_cycle
    import execute_cycle_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             ResultSrcE,
    input  logic             BranchE,
    input  logic             ALUSrcE,
    input  logic [2:0]       ALUControlE,
    input  logic [XLEN-1:0]  RD1_E,
    input  logic [XLEN-1:0]  RD2_E,
    input  logic [XLEN-1:0]  Imm_Ext_E,
    input  logic [XLEN-1:0]  PCE,
    input  logic [XLEN-1:0]  PCPlus4E,
    input  logic [REG_W-1:0] RS1_E,
    input  logic [REG_W-1:0] RS2_E,
    input  logic [REG_W-1:0] RD_E,
    input  logic [XLEN-1:0]  ResultW,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic             FlushE,
    output logic             PCSrcE,
    output logic [XLEN-1:0]  PCTargetE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             ResultSrcM,
    output logic [REG_W-1:0] RD_M,
    output logic [XLEN-1:0]  ALUResultM,
    output logic [XLEN-1:0]  WriteDataM,
    output logic [XLEN-1:0]  PCPlus4M
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    // Hazard unit indices are consumed upstream; kept for interface symmetry.
    logic unused_idx;
    assign unused_idx = ^{RS1_E, RS2_E};

`ifdef EXECUTE_FWD_EN
    // ALUResultM is the pre-edge registered value, so a dependent op issued
    // right behind its producer picks up the fresh result without a stall.
    always_comb begin
        src_a = RD1_E;
        case (ForwardAE)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUResultM;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        fwd_b = RD2_E;
        case (ForwardBE)
            FWD_WB:  fwd_b = ResultW;
            FWD_MEM: fwd_b = ALUResultM;
            default: fwd_b = RD2_E;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ForwardAE, ForwardBE, ResultW};

    assign src_a = RD1_E;
    assign fwd_b = RD2_E;
`endif

    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    ex_alu u_alu (
        .A          (src_a),
        .B          (src_b),
        .ALUControl (ALUControlE),
        .Result     (alu_result),
        .Zero       (alu_zero)
    );

    assign PCTargetE = PCE + Imm_Ext_E;
    assign PCSrcE    = BranchE & alu_zero & ~FlushE;

    // A flushed instruction still moves its data through; only the
    // architectural side effects (register/memory writes) are squashed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            RD_M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE & ~FlushE;
            MemWriteM  <= MemWriteE & ~FlushE;
            ResultSrcM <= ResultSrcE;
            RD_M       <= RD_E;
            ALUResultM <= alu_result;
            WriteDataM <= fwd_b;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle
//   Directed-vector bench for execute_cycle. The driver applies one
//   instruction per negedge, checks the combinational branch outputs, and
//   queues the expected EX/MEM contents; the monitor pops and compares one
//   entry after each rising edge.
module tb_execute_cycle;

`ifdef EXECUTE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RS1_E, RS2_E, RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        FlushE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
        .ResultW(ResultW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .FlushE(FlushE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw, mw, rs, br, alusrc;
        logic [2:0]  op;
        logic [31:0] rd1, rd2, imm, pce, pc4, resw;
        logic [4:0]  rs1, rs2, rd;
        logic [1:0]  fa, fb;
        logic        flush;
    } stim_t;

    typedef struct {
        string       name;
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
        logic        rw, mw, rs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input string nm, input logic [31:0] alu, input logic [31:0] wd,
                                input logic [4:0] rd, input logic rw, input logic mw,
                                input logic rs, input logic [31:0] pc4);
        exp_t e;
        e.name = nm; e.alu = alu; e.wd = wd; e.rd = rd;
        e.rw = rw; e.mw = mw; e.rs = rs; e.pc4 = pc4;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        RegWriteE = s.rw; MemWriteE = s.mw; ResultSrcE = s.rs; BranchE = s.br;
        ALUSrcE = s.alusrc; ALUControlE = s.op; RD1_E = s.rd1; RD2_E = s.rd2;
        Imm_Ext_E = s.imm; PCE = s.pce; PCPlus4E = s.pc4; ResultW = s.resw;
        RS1_E = s.rs1; RS2_E = s.rs2; RD_E = s.rd; ForwardAE = s.fa;
        ForwardBE = s.fb; FlushE = s.flush;
    endtask

    task automatic issue(input stim_t s, input logic pcsrc_x, input logic [31:0] pct_x, input exp_t e);
        @(negedge clk);
        apply(s);
        #1;
        chk({e.name, ".PCSrcE"}, {31'b0, PCSrcE}, {31'b0, pcsrc_x});
        chk({e.name, ".PCTargetE"}, PCTargetE, pct_x);
        exp_q.push_back(e);
    endtask

    task automatic chk_m_zero(input string nm);
        chk({nm, ".RegWriteM"},  {31'b0, RegWriteM}, 32'd0);
        chk({nm, ".MemWriteM"},  {31'b0, MemWriteM}, 32'd0);
        chk({nm, ".ResultSrcM"}, {31'b0, ResultSrcM}, 32'd0);
        chk({nm, ".RD_M"},       {27'b0, RD_M}, 32'd0);
        chk({nm, ".ALUResultM"}, ALUResultM, 32'd0);
        chk({nm, ".WriteDataM"}, WriteDataM, 32'd0);
        chk({nm, ".PCPlus4M"},   PCPlus4M, 32'd0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".ALUResultM"}, ALUResultM, e.alu);
                chk({e.name, ".WriteDataM"}, WriteDataM, e.wd);
                chk({e.name, ".RD_M"},       {27'b0, RD_M}, {27'b0, e.rd});
                chk({e.name, ".RegWriteM"},  {31'b0, RegWriteM}, {31'b0, e.rw});
                chk({e.name, ".MemWriteM"},  {31'b0, MemWriteM}, {31'b0, e.mw});
                chk({e.name, ".ResultSrcM"}, {31'b0, ResultSrcM}, {31'b0, e.rs});
                chk({e.name, ".PCPlus4M"},   PCPlus4M, e.pc4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Driver
    initial begin
        stim_t s;
        rst = 1'b0;
        s = '0;
        apply(s);
        #3;
        chk_m_zero("init_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        s = '0; s.rd1 = 32'd5; s.rd2 = 32'd9; s.imm = 32'd7; s.alusrc = 1'b1; s.rd = 5'd3;
        s.rw = 1'b1; s.pce = 32'h100; s.pc4 = 32'h104;
        issue(s, 1'b0, 32'h107, mk("add", 32'd12, 32'd9, 5'd3, 1'b1, 1'b0, 1'b0, 32'h104));

        s = '0; s.rd1 = 32'h10; s.rd2 = 32'h10; s.op = 3'b001; s.br = 1'b1; s.pce = 32'h100;
        s.imm = 32'hFFFF_FFF8; s.rd = 5'd4; s.pc4 = 32'h108;
        issue(s, 1'b1, 32'h0000_00F8, mk("br_taken", 32'd0, 32'h10, 5'd4, 1'b0, 1'b0, 1'b0, 32'h108));

        s.rd2 = 32'h11;
        issue(s, 1'b0, 32'h0000_00F8, mk("br_not", 32'hFFFF_FFFF, 32'h11, 5'd4, 1'b0, 1'b0, 1'b0, 32'h108));

        s = '0; s.rd1 = 32'h20; s.alusrc = 1'b1; s.rd = 5'd5; s.rw = 1'b1; s.pce = 32'h200; s.pc4 = 32'h204;
        issue(s, 1'b0, 32'h200, mk("produce", 32'h20, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h204));

        s = '0; s.fa = 2'b10; s.fb = 2'b01; s.resw = 32'h30; s.rd1 = 32'd1; s.rd2 = 32'd2;
        s.rd = 5'd6; s.rw = 1'b1; s.pce = 32'h204; s.pc4 = 32'h208;
        issue(s, 1'b0, 32'h204, mk("fwd_mem_wb", FWD ? 32'h50 : 32'h3, FWD ? 32'h30 : 32'h2,
                                   5'd6, 1'b1, 1'b0, 1'b0, 32'h208));

        s = '0; s.fa = 2'b10; s.rd1 = 32'd0; s.rd2 = 32'd7; s.imm = 32'h10; s.alusrc = 1'b1;
        s.rd = 5'd7; s.rw = 1'b1; s.pce = 32'h208; s.pc4 = 32'h20C;
        issue(s, 1'b0, 32'h218, mk("fwd_b2b", FWD ? 32'h60 : 32'h10, 32'd7, 5'd7, 1'b1, 1'b0, 1'b0, 32'h20C));

        s = '0; s.rd1 = 32'hF0F0_1234; s.rd2 = 32'h0FF0_FFFF; s.op = 3'b010; s.rd = 5'd8;
        s.pce = 32'h300; s.pc4 = 32'h304;
        issue(s, 1'b0, 32'h300, mk("and", 32'h00F0_1234, 32'h0FF0_FFFF, 5'd8, 1'b0, 1'b0, 1'b0, 32'h304));

        s.op = 3'b011;
        issue(s, 1'b0, 32'h300, mk("or", 32'hFFF0_FFFF, 32'h0FF0_FFFF, 5'd8, 1'b0, 1'b0, 1'b0, 32'h304));

        s = '0; s.rw = 1'b1; s.mw = 1'b1; s.rs = 1'b1; s.br = 1'b1; s.op = 3'b001;
        s.rd1 = 32'd7; s.rd2 = 32'd7; s.flush = 1'b1; s.rd = 5'd9; s.pce = 32'h400;
        s.imm = 32'h20; s.pc4 = 32'h404;
        issue(s, 1'b0, 32'h420, mk("flush", 32'd0, 32'd7, 5'd9, 1'b0, 1'b0, 1'b1, 32'h404));

        s = '0; s.rd1 = 32'd10; s.rd2 = 32'd3; s.op = 3'b001; s.br = 1'b1; s.rw = 1'b1;
        s.rd = 5'd10; s.pce = 32'h500; s.imm = 32'd8; s.pc4 = 32'h504;
        issue(s, 1'b0, 32'h508, mk("sub", 32'd7, 32'd3, 5'd10, 1'b1, 1'b0, 1'b0, 32'h504));

        s = '0; s.rd1 = 32'd5; s.rd2 = 32'd6; s.op = 3'b111; s.br = 1'b1; s.rd = 5'd11;
        s.pce = 32'h40; s.imm = 32'd4; s.pc4 = 32'h44;
        issue(s, 1'b1, 32'h44, mk("op_undef", 32'd0, 32'd6, 5'd11, 1'b0, 1'b0, 1'b0, 32'h44));

        s = '0; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 32'd1; s.op = 3'b101; s.rd = 5'd12; s.pc4 = 32'h600;
        issue(s, 1'b0, 32'h0, mk("slt_neg", 32'd1, 32'd1, 5'd12, 1'b0, 1'b0, 1'b0, 32'h600));

        s.rd1 = 32'd1; s.rd2 = 32'hFFFF_FFFF; s.br = 1'b1;
        issue(s, 1'b1, 32'h0, mk("slt_pos", 32'd0, 32'hFFFF_FFFF, 5'd12, 1'b0, 1'b0, 1'b0, 32'h600));

        s = '0; s.fa = 2'b11; s.fb = 2'b11; s.resw = 32'h99; s.rd1 = 32'd3; s.rd2 = 32'd4;
        s.rd = 5'd13; s.rw = 1'b1; s.mw = 1'b1; s.rs = 1'b1; s.pc4 = 32'h704;
        issue(s, 1'b0, 32'h0, mk("fwd_code11", 32'd7, 32'd4, 5'd13, 1'b1, 1'b1, 1'b1, 32'h704));

        // Asynchronous reset with every input nonzero, away from any edge.
        @(posedge clk);
        #3;
        s.rw = 1'b1; s.mw = 1'b1; s.rs = 1'b1; s.br = 1'b1; s.alusrc = 1'b1; s.op = 3'b001;
        s.rd1 = 32'd1; s.rd2 = 32'd2; s.imm = 32'd3; s.pce = 32'h10; s.pc4 = 32'h14;
        s.resw = 32'd5; s.rs1 = 5'd1; s.rs2 = 5'd2; s.rd = 5'd14; s.fa = 2'b01;
        s.fb = 2'b01; s.flush = 1'b1;
        apply(s);
        rst = 1'b0;
        #1;
        chk_m_zero("async_reset");
        chk("reset.PCTargetE", PCTargetE, 32'h13);
        @(posedge clk);
        #1;
        chk_m_zero("reset_held");

        s = '0; s.rd1 = 32'h40; s.imm = 32'h2; s.alusrc = 1'b1; s.rd = 5'd15; s.rw = 1'b1;
        s.pce = 32'h800; s.pc4 = 32'h804;
        apply(s);
        @(negedge clk);
        rst = 1'b1;
        issue(s, 1'b0, 32'h802, mk("post_reset", 32'h42, 32'h0, 5'd15, 1'b1, 1'b0, 1'b0, 32'h804));

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
